// File: rtl/counter_read_ctrl.sv
// Sweeps NUM_CNT push counters through their req/idx read port on a start
// pulse and returns one packed snapshot, with a per-read response watchdog.
module counter_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CNT    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          idle,
  output logic                          req,
  output logic [IDX_WIDTH-1:0]          idx,
  input  logic                          valid_cont,
  input  logic [DATA_WIDTH-1:0]         data_cont,
  output logic [NUM_CNT*DATA_WIDTH-1:0] snap_data,
  output logic                          snap_valid,
  output logic                          busy,
  output logic [NUM_CNT-1:0]            err_mask
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CNT - 1);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_REQ,
    S_WAIT_VALID,
    S_DONE
  } state_t;

  state_t                          state_q;
  logic [IDX_WIDTH-1:0]            ptr_q;
  logic [WD_W-1:0]                 wd_q;
  logic                            req_q;
  logic [IDX_WIDTH-1:0]            idx_q;
  logic [NUM_CNT*DATA_WIDTH-1:0]   snap_q;
  logic                            snap_valid_q;
  logic                            busy_q;
  logic [NUM_CNT-1:0]              err_q;

  // A read finishes either on a response or when the watchdog expires.
  logic                            read_done_d;
  assign read_done_d = valid_cont || (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      wd_q         <= '0;
      req_q        <= 1'b0;
      idx_q        <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      req_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_WAIT_IDLE;
            ptr_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (idle) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            idx_q   <= ptr_q;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT_VALID;
          wd_q    <= '0;
        end
        S_WAIT_VALID: begin
          if (read_done_d) begin
            if (valid_cont) begin
              snap_q[ptr_q*DATA_WIDTH +: DATA_WIDTH] <= data_cont;
            end else begin
              snap_q[ptr_q*DATA_WIDTH +: DATA_WIDTH] <= '0;
              err_q[ptr_q]                           <= 1'b1;
            end
            if (ptr_q == LAST_IDX) begin
              state_q      <= S_DONE;
              snap_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_IDLE;
              ptr_q   <= ptr_q + 1'b1;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req        = req_q;
  assign idx        = idx_q;
  assign snap_data  = snap_q;
  assign snap_valid = snap_valid_q;
  assign busy       = busy_q;
  assign err_mask   = err_q;

endmodule

// File: tb/tb_counter_read_ctrl.sv
// Directed bench for counter_read_ctrl: a one-cycle-latency counter model
// drives the read port while each sweep's outputs are logged per cycle.
module tb_counter_read_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        idle;
  logic        req;
  logic [1:0]  idx;
  logic        valid_cont;
  logic [7:0]  data_cont;
  logic [31:0] snap_data;
  logic        snap_valid;
  logic        busy;
  logic [3:0]  err_mask;

  counter_read_ctrl #(
    .DATA_WIDTH(8), .NUM_CNT(4), .IDX_WIDTH(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .idle(idle),
    .req(req), .idx(idx), .valid_cont(valid_cont), .data_cont(data_cont),
    .snap_data(snap_data), .snap_valid(snap_valid), .busy(busy),
    .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [31:0] snap_log [64];
  logic [3:0]  err_log  [64];
  logic        busy_log [64];
  int          req_c [16];
  int          req_i [16];
  int          nreq, nsnap, snap_first, snap_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sweep run for ncyc cycles; rel cycle 0 carries the start pulse.
  task automatic sweep(input int ncyc, input int idle_lo, input int idle_hi,
                       input int start2, input int stray, input int rst_c,
                       input int noresp);
    logic       pend;
    logic [7:0] pd;
    int         rnum;
    pend = 1'b0; pd = '0; rnum = 0;
    nreq = 0; nsnap = 0; snap_first = -1; snap_last = -1;
    for (int r = 0; r < ncyc; r++) begin
      @(posedge clk);
      #1;
      snap_log[r] = snap_data;
      err_log[r]  = err_mask;
      busy_log[r] = busy;
      if (snap_valid) begin
        nsnap++;
        if (snap_first < 0) snap_first = r;
        snap_last = r;
      end
      valid_cont = pend;
      data_cont  = pd;
      pend = req && (rnum != noresp);
      pd   = vals[idx];
      if (req) begin
        if (nreq < 16) begin
          req_c[nreq] = r;
          req_i[nreq] = int'(idx);
        end
        nreq++;
        rnum++;
      end
      if (r == stray) begin
        valid_cont = 1'b1;
        data_cont  = 8'hFF;
      end
      start = (r == 0) || (r == start2);
      idle  = !((r >= idle_lo) && (r <= idle_hi));
      if (r == rst_c) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_req",   req,        1'b0);
        chk("rst_mid_busy",  busy,       1'b0);
        chk("rst_mid_snap",  snap_data,  32'h0);
        chk("rst_mid_sv",    snap_valid, 1'b0);
        chk("rst_mid_idx",   idx,        2'd0);
        pend = 1'b0;
      end else if (r == rst_c + 1) begin
        reset = 1'b0;
      end
    end
    start = 1'b0;
    valid_cont = 1'b0;
  endtask

  task automatic check_full(input string tag, input int base, input int sv_at);
    bit all_busy;
    chk({tag, "_nreq"}, nreq, 4);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_reqc"}, req_c[k], base + 3 * k);
      chk({tag, "_reqi"}, req_i[k], k);
    end
    chk({tag, "_nsnap"}, nsnap, 1);
    chk({tag, "_svat"},  snap_first, sv_at);
    chk({tag, "_data"},  snap_log[sv_at], 32'h44332211);
    chk({tag, "_err"},   err_log[sv_at], 4'h0);
    all_busy = 1'b1;
    for (int r = 1; r <= sv_at; r++) if (!busy_log[r]) all_busy = 1'b0;
    chk({tag, "_busy_on"},  all_busy, 1'b1);
    chk({tag, "_busy_off"}, busy_log[sv_at + 1], 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; idle = 1'b1;
    valid_cont = 1'b0; data_cont = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req",  req,        1'b0);
    chk("reset_idx",  idx,        2'd0);
    chk("reset_snap", snap_data,  32'h0);
    chk("reset_sv",   snap_valid, 1'b0);
    chk("reset_busy", busy,       1'b0);
    chk("reset_err",  err_mask,   4'h0);
    reset = 1'b0;

    // Basic sweep
    sweep(20, 100, -1, -1, -1, -1, -1);
    chk("basic_busy0", busy_log[0], 1'b0);
    check_full("basic", 2, 13);

    // Idle low for cycles 4..9: idx 1 request waits until cycle 11
    sweep(26, 4, 9, -1, -1, -1, -1);
    chk("stall_nreq", nreq, 4);
    chk("stall_req1", req_c[1], 11);
    chk("stall_req2", req_c[2], 14);
    chk("stall_req3", req_c[3], 17);
    chk("stall_sv",   snap_first, 19);
    chk("stall_data", snap_log[19], 32'h44332211);
    begin
      bit all_busy = 1'b1;
      for (int r = 1; r <= 19; r++) if (!busy_log[r]) all_busy = 1'b0;
      chk("stall_busy", all_busy, 1'b1);
    end

    // Extra start in REQ cycle, stray 0xFF valid during WAIT_IDLE
    sweep(30, 100, -1, 5, 4, -1, -1);
    check_full("ign", 2, 13);

    // Reset asserted between edges during WAIT_VALID of idx 1
    sweep(14, 100, -1, -1, -1, 6, -1);
    chk("rst_nsnap", nsnap, 0);
    chk("rst_nreq",  nreq, 2);
    chk("rst_snap_after", snap_log[13], 32'h0);
    sweep(20, 100, -1, -1, -1, -1, -1);
    check_full("post_rst", 2, 13);

    // Timeout on idx 2, then back-to-back sweep started right after snap_valid
    sweep(40, 100, -1, 21, -1, -1, 2);
    chk("to_nreq",     nreq, 8);
    chk("to_req3c",    req_c[3], 18);
    chk("to_req3i",    req_i[3], 3);
    chk("to_err16",    err_log[16], 4'h0);
    chk("to_err17",    err_log[17], 4'h4);
    chk("to_sv1",      snap_first, 20);
    chk("to_data",     snap_log[20], 32'h44002211);
    chk("to_err",      err_log[20], 4'h4);
    chk("b2b_idle21",  busy_log[21], 1'b0);
    chk("b2b_errclr",  err_log[22], 4'h0);
    chk("b2b_req4c",   req_c[4], 23);
    chk("b2b_nsnap",   nsnap, 2);
    chk("b2b_sv2",     snap_last, 34);
    chk("b2b_data",    snap_log[34], 32'h44332211);
    chk("b2b_err",     err_log[34], 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
